// File: rtl/perceptron_acc.sv
// perceptron_acc: collects N signed-weighted operand beats into an
// accumulator, then holds the sum and its threshold decision until the
// consumer takes it. The operand weights are +1 or -1, selected by in_neg.
module perceptron_acc #(
  parameter int W  = 4,
  parameter int N  = 3,
  parameter int TH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_neg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W+$clog2(N):0]   out_sum,
  output logic                   out_fire
);

  // Accumulator magnitude width. One extra sign bit makes the signed range
  // cover N worst-case operands of either sign, so no saturation is needed.
  localparam int SW = W + $clog2(N);
  // Beat counter must be able to hold the value N itself.
  localparam int CW = $clog2(N + 1);

  localparam logic signed [SW:0] TH_V    = (SW + 1)'(TH);
  localparam logic [CW-1:0]      LAST_CNT = CW'(N - 1);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic signed [SW:0]    acc_reg, acc_next;
  logic [CW-1:0]         cnt_reg, cnt_next;

  // Operand zero-extended to accumulator width before add/subtract.
  logic signed [SW:0]    operand;
  logic                  beat_accept;

  assign operand = {{(SW + 1 - W){1'b0}}, in_data};

  // Ready only in ACC; reset masks it so no beat looks accepted during reset.
  assign in_ready    = (state_reg == ACC) && !rst;
  assign out_valid   = (state_reg == DONE);
  assign beat_accept = in_valid && in_ready;

  assign out_sum  = acc_reg;
  // Threshold decision on the registered sum; meaningful while out_valid=1.
  assign out_fire = (acc_reg >= TH_V);

  // State, accumulator and counter registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: accumulate beats in ACC, release the result in DONE.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ACC: begin
        if (beat_accept) begin
          acc_next = in_neg ? (acc_reg - operand) : (acc_reg + operand);
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Incoming beats are ignored here; only the output handshake moves on.
        if (out_ready) begin
          state_next = ACC;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

endmodule

// File: tb/tb_perceptron_acc.sv
// Scoreboard bench for perceptron_acc: a reference model collects operands
// as plain integers and pushes each expected sum; a monitor compares the
// handshake signals and the presented result every cycle.
module tb_perceptron_acc;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int TH = 16;
  localparam int SW = W + $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_neg = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic          out_fire;
  logic [SW:0]   out_sum;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int beats[$];
  int exp_q[$];
  bit pending = 1'b0;
  bit mon_en = 1'b0;
  bit rnd_stop = 1'b0;

  perceptron_acc #(.W(W), .N(N), .TH(TH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_fire  (out_fire)
  );

  always #5 clk = ~clk;

  // Reference model: operands are signed integers, result is their plain sum.
  always @(posedge clk) begin
    if (rst) begin
      beats.delete();
      exp_q.delete();
      pending = 1'b0;
    end else if (pending) begin
      if (out_ready) begin
        void'(exp_q.pop_front());
        pending = 1'b0;
      end
    end else if (in_valid) begin
      beats.push_back(in_neg ? -int'(in_data) : int'(in_data));
      if (beats.size() == N) begin
        int s;
        s = 0;
        foreach (beats[i]) s += beats[i];
        exp_q.push_back(s);
        beats.delete();
        pending = 1'b1;
      end
    end
  end

  // Monitor: checks handshake signals every cycle and the result while shown.
  always @(negedge clk) begin
    if (mon_en) begin
      bit e_ir;
      bit e_ov;
      e_ir = !pending && !rst;
      e_ov = pending;
      tests++;
      if (in_ready !== e_ir || out_valid !== e_ov) begin
        fails++;
        $display("FAIL handshake t=%0t: in_ready=%b out_valid=%b, required in_ready=%b out_valid=%b",
                 $time, in_ready, out_valid, e_ir, e_ov);
      end
      if (pending && exp_q.size() > 0) begin
        int s;
        int got;
        bit e_fire;
        s = exp_q[0];
        e_fire = (s >= TH);
        got = int'($signed(out_sum));
        tests++;
        if (got != s || out_fire !== e_fire) begin
          fails++;
          $display("FAIL result t=%0t: out_sum=%0d out_fire=%b, required out_sum=%0d out_fire=%b",
                   $time, got, out_fire, s, e_fire);
        end
        if (out_ready && !rst)
          $display("[TB] result t=%0t sum=%0d fire=%b (expected %0d/%b)",
                   $time, got, out_fire, s, e_fire);
      end
    end
  end

  // Offer one beat and hold it until the model says it is taken.
  task automatic beat(input int v, input bit neg);
    int n;
    n = 0;
    in_data  = v[W-1:0];
    in_neg   = neg;
    in_valid = 1'b1;
    @(negedge clk);
    while (pending || rst) begin
      n++;
      if (n > 500) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: beat %0d not accepted within 500 cycles", v);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (pending) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: result not consumed within 500 cycles");
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset values of the result outputs
    @(negedge clk);
    tests++;
    if (out_sum !== '0 || out_fire !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: out_sum=%0d out_fire=%b, required 0/0", out_sum, out_fire);
    end
    @(posedge clk);
    #1;

    // Back-to-back basic sum
    beat(12, 0); beat(10, 0); beat(8, 0); drain();
    // Threshold boundary
    beat(12, 0); beat(3, 0); beat(1, 0); drain();
    beat(12, 0); beat(3, 0); beat(0, 0); drain();
    // Mixed signs and extremes
    beat(12, 0); beat(13, 1); beat(7, 0); drain();
    beat(15, 0); beat(15, 0); beat(15, 0); drain();
    beat(15, 1); beat(15, 1); beat(15, 1); drain();

    // Backpressure with beats offered while holding
    out_ready = 1'b0;
    beat(12, 0); beat(10, 0); beat(8, 0);
    in_data = 5; in_neg = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    idle(1);

    // Reset mid-accumulation discards partial operands
    beat(5, 0); beat(5, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    beat(1, 0); beat(1, 0); beat(1, 0); drain();

    // Reset while holding a result
    out_ready = 1'b0;
    beat(1, 0); beat(2, 0); beat(3, 0);
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Gaps between beats
    beat(2, 0); idle(2); beat(3, 0); idle(1); beat(4, 0); drain();

    // Randomized beats, gaps and backpressure
    fork
      begin
        repeat (300) begin
          beat(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        rnd_stop = 1'b1;
      end
      begin
        while (!rnd_stop) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perceptron_acc.md
PERCEPTRON_ACC -- requirements
Module: perceptron_acc

Interface
REQ-001 SHALL provide parameter W, default 4: width of each unsigned input operand.
REQ-002 SHALL provide parameter N, default 3: number of operands per result (N >= 2).
REQ-003 SHALL provide parameter TH, default 16: signed firing threshold, representable in SW+1 bits.
REQ-004 SHALL derive local SW = W + ceil(log2(N)); result width is SW+1 bits, two's complement (defaults: SW=6, result 7 bits).
REQ-005 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  operand beat offered.
REQ-009 in_ready  output  1  block can accept an operand beat.
REQ-010 in_data  input  W  unsigned operand magnitude.
REQ-011 in_neg  input  1  1 = subtract operand (weight -1), 0 = add (weight +1).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_sum  output  SW+1  signed accumulated sum.
REQ-015 out_fire  output  1  1 when out_sum >= TH (signed compare).

Function
REQ-016 SHALL implement two states: ACC (collecting operands) and DONE (holding result).
REQ-017 In ACC: in_ready=1, out_valid=0; beat accepted when in_valid && in_ready on a clock edge.
REQ-018 On each accepted beat: acc <= acc + in_data, or acc - in_data if in_neg=1; operand zero-extended to SW+1 bits before add/subtract; beat counter increments.
REQ-019 No overflow SHALL be possible: range -(N*(2^W-1)) .. +N*(2^W-1) fits SW+1 signed bits; no saturation logic.
REQ-020 Cycles with in_valid=0 in ACC SHALL leave acc and counter unchanged (gaps allowed).
REQ-021 On the Nth accepted beat, transition to DONE; out_valid=1 in the very next cycle (latency 1 cycle after final beat), out_sum including the Nth operand.
REQ-022 In DONE: in_ready=0, out_valid=1, out_sum and out_fire stable until handshake.
REQ-023 DONE -> ACC when out_valid && out_ready; same edge clears acc and counter to 0; in_ready=1 next cycle.
REQ-024 in_valid while in DONE SHALL be ignored (no beat accepted, no state change).
REQ-025 out_fire SHALL be combinational on the registered sum and meaningful only while out_valid=1; it equals 0 when sum = TH-1 and 1 when sum = TH.
REQ-026 Counter SHALL be ceil(log2(N+1)) bits wide, wrapping to 0 only through REQ-023 or reset.
REQ-027 Minimum period between results SHALL be N+1 cycles (N beats + 1 DONE cycle with out_ready=1).

Reset
REQ-028 When rst=1 at a clock edge: state=ACC, acc=0, counter=0; next cycle in_ready=1, out_valid=0, out_sum=0, out_fire=(0>=TH).
REQ-029 rst SHALL take priority over any simultaneous beat or output handshake; partially accumulated operands are discarded.
REQ-030 While rst=1, in_ready SHALL read 0; no beat is accepted.

Verification (defaults W=4, N=3, TH=16)
REQ-031 Beats 12,10,8 all in_neg=0, back-to-back, out_ready=1 -> out_valid 1 cycle after third beat, out_sum=30, out_fire=1, then in_ready=1.
REQ-032 Beats 12,+3,+1 -> out_sum=16, out_fire=1; beats 12,+3,+0 -> out_sum=15, out_fire=0 (threshold boundary).
REQ-033 Beats 12, -13 (in_neg=1), +7 -> out_sum=6, out_fire=0; extremes 15,15,15 -> 45 and -15,-15,-15 -> -45 (7'b1010011).
REQ-034 Result 30 with out_ready=0 for 5 cycles, in_valid=1 meanwhile -> out_valid held, out_sum stays 30, in_ready=0, no beat consumed; raise out_ready -> ACC next cycle.
REQ-035 Beats 5,5 then rst=1 for one cycle, then beats 1,1,1 -> out_sum=3 (pre-reset operands discarded); rst asserted in DONE -> out_valid=0 next cycle.
REQ-036 Beats 2,gap,gap,3,gap,4 (in_valid toggled) -> out_sum=9, only three beats counted.
